// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-ported data memory.
// Optional starvation guard for the debug port is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_done,
    output logic       cpu_stall,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic [7:0] dbg_rdata,
    output logic       dbg_done,
    output logic       mem_rm,
    output logic       mem_wm,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic       owner_dbg;
    logic       lat_we;
    logic       dbg_wins;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

`ifdef DMEM_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    // Debug overrides CPU priority once the CPU has won STARVE_LIMIT times in a row.
    always_comb begin
        dbg_wins = dbg_req & (~cpu_req | (starve_cnt == 4'(STARVE_LIMIT)));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!dbg_req || dbg_wins) begin
                starve_cnt <= 4'd0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    always_comb begin
        dbg_wins = dbg_req & ~cpu_req;
    end
`endif

    always_comb begin
        sel_we    = dbg_wins ? dbg_we    : cpu_we;
        sel_addr  = dbg_wins ? dbg_addr  : cpu_addr;
        sel_wdata = dbg_wins ? dbg_wdata : cpu_wdata;
    end

    assign cpu_stall = cpu_req & ~cpu_done;

    // mem_addr / mem_wdata double as the latched address and store data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner_dbg <= 1'b0;
            lat_we    <= 1'b0;
            mem_rm    <= 1'b0;
            mem_wm    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            cpu_rdata <= 8'h00;
            dbg_rdata <= 8'h00;
            cpu_done  <= 1'b0;
            dbg_done  <= 1'b0;
        end else begin
            mem_rm   <= 1'b0;
            mem_wm   <= 1'b0;
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner_dbg <= dbg_wins;
                        lat_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_rm    <= ~sel_we;
                        mem_wm    <= sel_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (owner_dbg) begin
                            dbg_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    if (owner_dbg) begin
                        dbg_done <= 1'b1;
                    end else begin
                        cpu_done <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
